hpc_ctrl: RTL and testbench

- Control and readout sequencer for the core's hardware performance counter (HPC) bank.
- Owns the bank's global count-enable and synchronous clear.
- Captures a coherent snapshot of all counters into shadow registers.
- Arbitrates two read requesters onto the shadow bank: core CSR path (C) and debug port (D). 64-bit cycle reads are atomic.

---
 rtl/hpc_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_hpc_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpc_ctrl.sv
// -----------------------------------------------------------------------------
// hpc_ctrl
// Control and readout sequencer for the hardware performance counter bank.
// Owns the global count enable and clear pulse, snapshots the cycle counter
// and the event counters into shadow registers, and serves 32-bit reads of
// the shadows to two requesters (C = core CSR path, D = debug port).
//
// Ports
//   clk, rst_i               clock, synchronous active-high reset
//   cmd_valid/cmd_op/ready   command handshake (1 START, 2 STOP, 3 CLEAR, 4 SNAP)
//   cnt_en_o, cnt_clr_o      counter bank enable / one-cycle clear
//   cyc_i, cnt_val_i         live cycle counter and NUM_CNT event counters
//   req_x_valid/addr/ready   read request per requester (x = c, d)
//   rsp_x_valid/data/err     registered read response per requester
//
// Address map: 0 cyc[31:0] (latches cyc[63:32] into that requester's hi hold),
// 1 hi hold, 2..NUM_CNT+1 event counters, anything else returns err.
//
// state       | meaning
// ST_STOPPED  | counters frozen
// ST_RUNNING  | counters enabled
// ST_CLEARING | one-cycle clear pulse, then back to the state saved in ret_run
// -----------------------------------------------------------------------------
module hpc_ctrl #(
  parameter int NUM_CNT = 8,
  parameter int ADDR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  cmd_valid,
  input  logic [2:0]            cmd_op,
  output logic                  cmd_ready,
  output logic                  cnt_en_o,
  output logic                  cnt_clr_o,
  input  logic [63:0]           cyc_i,
  input  logic [NUM_CNT*32-1:0] cnt_val_i,
  input  logic                  req_c_valid,
  input  logic [ADDR_W-1:0]     req_c_addr,
  output logic                  req_c_ready,
  input  logic                  req_d_valid,
  input  logic [ADDR_W-1:0]     req_d_addr,
  output logic                  req_d_ready,
  output logic                  rsp_c_valid,
  output logic [31:0]           rsp_c_data,
  output logic                  rsp_c_err,
  output logic                  rsp_d_valid,
  output logic [31:0]           rsp_d_data,
  output logic                  rsp_d_err
);

  localparam logic [2:0] OP_START = 3'd1;
  localparam logic [2:0] OP_STOP  = 3'd2;
  localparam logic [2:0] OP_CLEAR = 3'd3;
  localparam logic [2:0] OP_SNAP  = 3'd4;

  typedef enum logic [1:0] {
    ST_STOPPED  = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_CLEARING = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_ret_run;
  logic        w_ret_run_nxt;
  logic        r_cnt_en;
  logic        r_cnt_clr;
  logic        w_cmd_acc;
  logic        w_snap;

  logic [63:0] r_shadow_cyc;
  logic [31:0] r_shadow [NUM_CNT];
  logic [31:0] r_hi_c;
  logic [31:0] r_hi_d;
  logic        r_rr_d;        // 1: pointer on D, 0: pointer on C

  logic        w_gnt_c;
  logic        w_gnt_d;
  logic [31:0] w_rd_c_data;
  logic        w_rd_c_err;
  logic [31:0] w_rd_d_data;
  logic        w_rd_d_err;

  logic        r_rsp_c_valid;
  logic [31:0] r_rsp_c_data;
  logic        r_rsp_c_err;
  logic        r_rsp_d_valid;
  logic [31:0] r_rsp_d_data;
  logic        r_rsp_d_err;

  assign cmd_ready = (r_state != ST_CLEARING);
  assign w_cmd_acc = cmd_valid && cmd_ready;
  assign w_snap    = w_cmd_acc && (cmd_op == OP_SNAP);
  assign cnt_en_o  = r_cnt_en;
  assign cnt_clr_o = r_cnt_clr;

  always_comb begin
    w_state_nxt   = r_state;
    w_ret_run_nxt = r_ret_run;
    case (r_state)
      ST_STOPPED: begin
        if (w_cmd_acc && cmd_op == OP_START) begin
          w_state_nxt = ST_RUNNING;
        end else if (w_cmd_acc && cmd_op == OP_CLEAR) begin
          w_state_nxt   = ST_CLEARING;
          w_ret_run_nxt = 1'b0;
        end
      end
      ST_RUNNING: begin
        if (w_cmd_acc && cmd_op == OP_STOP) begin
          w_state_nxt = ST_STOPPED;
        end else if (w_cmd_acc && cmd_op == OP_CLEAR) begin
          w_state_nxt   = ST_CLEARING;
          w_ret_run_nxt = 1'b1;
        end
      end
      ST_CLEARING: w_state_nxt = r_ret_run ? ST_RUNNING : ST_STOPPED;
      default:     w_state_nxt = ST_STOPPED;
    endcase
  end

  // Ready is purely combinational: a lone requester always wins, a tie goes
  // to the round-robin pointer.
  assign w_gnt_c     = req_c_valid && (!req_d_valid || !r_rr_d);
  assign w_gnt_d     = req_d_valid && (!req_c_valid ||  r_rr_d);
  assign req_c_ready = w_gnt_c;
  assign req_d_ready = w_gnt_d;

  // Event-counter region of the map; returns {err, data}.
  function automatic logic [32:0] rd_cnt(input logic [ADDR_W-1:0] addr);
    logic [32:0] v;
    v = {1'b1, 32'h0};
    for (int k = 0; k < NUM_CNT; k++) begin
      if (addr == ADDR_W'(k + 2)) v = {1'b0, r_shadow[k]};
    end
    return v;
  endfunction

  always_comb begin
    w_rd_c_data = 32'h0;
    w_rd_c_err  = 1'b0;
    if (req_c_addr == ADDR_W'(0))      w_rd_c_data = r_shadow_cyc[31:0];
    else if (req_c_addr == ADDR_W'(1)) w_rd_c_data = r_hi_c;
    else {w_rd_c_err, w_rd_c_data} = rd_cnt(req_c_addr);
  end

  always_comb begin
    w_rd_d_data = 32'h0;
    w_rd_d_err  = 1'b0;
    if (req_d_addr == ADDR_W'(0))      w_rd_d_data = r_shadow_cyc[31:0];
    else if (req_d_addr == ADDR_W'(1)) w_rd_d_data = r_hi_d;
    else {w_rd_d_err, w_rd_d_data} = rd_cnt(req_d_addr);
  end

  // A read and a SNAP on the same edge: the response register captures the
  // old shadow while the shadows take the new snapshot.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_state       <= ST_STOPPED;
      r_ret_run     <= 1'b0;
      r_cnt_en      <= 1'b0;
      r_cnt_clr     <= 1'b0;
      r_shadow_cyc  <= 64'h0;
      for (int k = 0; k < NUM_CNT; k++) r_shadow[k] <= 32'h0;
      r_hi_c        <= 32'h0;
      r_hi_d        <= 32'h0;
      r_rr_d        <= 1'b0;
      r_rsp_c_valid <= 1'b0;
      r_rsp_c_data  <= 32'h0;
      r_rsp_c_err   <= 1'b0;
      r_rsp_d_valid <= 1'b0;
      r_rsp_d_data  <= 32'h0;
      r_rsp_d_err   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ret_run <= w_ret_run_nxt;
      r_cnt_en  <= (w_state_nxt == ST_RUNNING);
      r_cnt_clr <= (w_state_nxt == ST_CLEARING);
      if (w_snap) begin
        r_shadow_cyc <= cyc_i;
        for (int k = 0; k < NUM_CNT; k++) r_shadow[k] <= cnt_val_i[32*k +: 32];
      end
      if (w_gnt_c && req_c_addr == ADDR_W'(0)) r_hi_c <= r_shadow_cyc[63:32];
      if (w_gnt_d && req_d_addr == ADDR_W'(0)) r_hi_d <= r_shadow_cyc[63:32];
      if (w_gnt_c)      r_rr_d <= 1'b1;
      else if (w_gnt_d) r_rr_d <= 1'b0;
      r_rsp_c_valid <= w_gnt_c;
      r_rsp_c_data  <= w_gnt_c ? w_rd_c_data : 32'h0;
      r_rsp_c_err   <= w_gnt_c && w_rd_c_err;
      r_rsp_d_valid <= w_gnt_d;
      r_rsp_d_data  <= w_gnt_d ? w_rd_d_data : 32'h0;
      r_rsp_d_err   <= w_gnt_d && w_rd_d_err;
    end
  end

  assign rsp_c_valid = r_rsp_c_valid;
  assign rsp_c_data  = r_rsp_c_data;
  assign rsp_c_err   = r_rsp_c_err;
  assign rsp_d_valid = r_rsp_d_valid;
  assign rsp_d_data  = r_rsp_d_data;
  assign rsp_d_err   = r_rsp_d_err;

endmodule

// File: tb/tb_hpc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hpc_ctrl
// Bench for hpc_ctrl. Each test task drives its own stimulus; read responses
// are predicted at request time into per-requester queues (with the cycle the
// response is due) and retired by the negedge monitor.
// -----------------------------------------------------------------------------
module tb_hpc_ctrl;
  localparam int NUM_CNT = 8;
  localparam int ADDR_W  = 4;

  logic                  clk = 1'b0;
  logic                  rst_i = 1'b0;
  logic                  cmd_valid = 1'b0;
  logic [2:0]            cmd_op = 3'd0;
  logic                  cmd_ready;
  logic                  cnt_en_o;
  logic                  cnt_clr_o;
  logic [63:0]           cyc_i = 64'h0;
  logic [NUM_CNT*32-1:0] cnt_val_i = '0;
  logic                  req_c_valid = 1'b0;
  logic [ADDR_W-1:0]     req_c_addr = '0;
  logic                  req_c_ready;
  logic                  req_d_valid = 1'b0;
  logic [ADDR_W-1:0]     req_d_addr = '0;
  logic                  req_d_ready;
  logic                  rsp_c_valid;
  logic [31:0]           rsp_c_data;
  logic                  rsp_c_err;
  logic                  rsp_d_valid;
  logic [31:0]           rsp_d_data;
  logic                  rsp_d_err;

  always #5 clk = ~clk;

  hpc_ctrl #(.NUM_CNT(NUM_CNT), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_i(rst_i),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .cnt_en_o(cnt_en_o), .cnt_clr_o(cnt_clr_o),
    .cyc_i(cyc_i), .cnt_val_i(cnt_val_i),
    .req_c_valid(req_c_valid), .req_c_addr(req_c_addr), .req_c_ready(req_c_ready),
    .req_d_valid(req_d_valid), .req_d_addr(req_d_addr), .req_d_ready(req_d_ready),
    .rsp_c_valid(rsp_c_valid), .rsp_c_data(rsp_c_data), .rsp_c_err(rsp_c_err),
    .rsp_d_valid(rsp_d_valid), .rsp_d_data(rsp_d_data), .rsp_d_err(rsp_d_err)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q_c[$];
  exp_t q_d[$];
  exp_t mx_c;
  exp_t mx_d;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc_cnt  = 0;

  always @(posedge clk) cyc_cnt++;

  // Scoreboard: a response is due exactly one cycle after the request edge.
  always @(negedge clk) begin
    if (rsp_c_valid === 1'b1) begin
      n_checks++;
      if (q_c.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_c_unexpected got data=%h err=%b at cycle %0d, none expected",
                 rsp_c_data, rsp_c_err, cyc_cnt);
      end else begin
        mx_c = q_c.pop_front();
        if (rsp_c_data !== mx_c.data || rsp_c_err !== mx_c.err || cyc_cnt != mx_c.cyc) begin
          n_fail++;
          $display("FAIL rsp_c got data=%h err=%b cycle=%0d, expected data=%h err=%b cycle=%0d",
                   rsp_c_data, rsp_c_err, cyc_cnt, mx_c.data, mx_c.err, mx_c.cyc);
        end
      end
    end else if (q_c.size() > 0 && q_c[0].cyc <= cyc_cnt) begin
      n_checks++;
      n_fail++;
      mx_c = q_c.pop_front();
      $display("FAIL rsp_c_missing got valid=%b at cycle %0d, expected data=%h", rsp_c_valid,
               cyc_cnt, mx_c.data);
    end
    if (rsp_d_valid === 1'b1) begin
      n_checks++;
      if (q_d.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_d_unexpected got data=%h err=%b at cycle %0d, none expected",
                 rsp_d_data, rsp_d_err, cyc_cnt);
      end else begin
        mx_d = q_d.pop_front();
        if (rsp_d_data !== mx_d.data || rsp_d_err !== mx_d.err || cyc_cnt != mx_d.cyc) begin
          n_fail++;
          $display("FAIL rsp_d got data=%h err=%b cycle=%0d, expected data=%h err=%b cycle=%0d",
                   rsp_d_data, rsp_d_err, cyc_cnt, mx_d.data, mx_d.err, mx_d.cyc);
        end
      end
    end else if (q_d.size() > 0 && q_d[0].cyc <= cyc_cnt) begin
      n_checks++;
      n_fail++;
      mx_d = q_d.pop_front();
      $display("FAIL rsp_d_missing got valid=%b at cycle %0d, expected data=%h", rsp_d_valid,
               cyc_cnt, mx_d.data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout, expected bench completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cmd_valid   = 1'b0;
    cmd_op      = 3'd0;
    req_c_valid = 1'b0;
    req_d_valid = 1'b0;
  endtask

  task automatic cmd(input logic [2:0] op);
    cmd_valid = 1'b1;
    cmd_op    = op;
  endtask

  task automatic rd_c(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic e);
    exp_t x;
    req_c_valid = 1'b1;
    req_c_addr  = a;
    x.data = d; x.err = e; x.cyc = cyc_cnt + 1;
    q_c.push_back(x);
  endtask

  task automatic rd_d(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic e);
    exp_t x;
    req_d_valid = 1'b1;
    req_d_addr  = a;
    x.data = d; x.err = e; x.cyc = cyc_cnt + 1;
    q_d.push_back(x);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    q_c.delete();
    q_d.delete();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++;
    if (cnt_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_cnt_en got=%b exp=0", cnt_en_o); end
    n_checks++;
    if (cnt_clr_o !== 1'b0) begin n_fail++; $display("FAIL reset_cnt_clr got=%b exp=0", cnt_clr_o); end
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    n_checks++;
    if (rsp_c_valid !== 1'b0 || rsp_d_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_rsp_valid got c=%b d=%b exp 0 0", rsp_c_valid, rsp_d_valid);
    end
    rd_c(4'd0, 32'h0, 1'b0);
    tick();
    rd_d(4'd1, 32'h0, 1'b0);
    tick();
    tick();
    n_checks++;
    if (q_c.size() + q_d.size() != 0) begin
      n_fail++; $display("FAIL reset_drain got pending=%0d exp=0", q_c.size() + q_d.size());
    end
  endtask

  task automatic test_run_stop();
    cmd(3'd1);
    tick();
    @(negedge clk);
    n_checks++;
    if (cnt_en_o !== 1'b1) begin n_fail++; $display("FAIL start_cnt_en got=%b exp=1", cnt_en_o); end
    cmd(3'd1);                      // START while running: no-op
    tick();
    cmd(3'd2);
    tick();
    @(negedge clk);
    n_checks++;
    if (cnt_en_o !== 1'b0) begin n_fail++; $display("FAIL stop_cnt_en got=%b exp=0", cnt_en_o); end
  endtask

  task automatic test_clear();
    cmd(3'd1);
    tick();
    cmd(3'd3);
    tick();
    @(negedge clk);
    n_checks++;
    if ({cnt_clr_o, cnt_en_o, cmd_ready} !== 3'b100) begin
      n_fail++; $display("FAIL clear_run_pulse got clr/en/rdy=%b exp=100", {cnt_clr_o, cnt_en_o, cmd_ready});
    end
    tick();
    @(negedge clk);
    n_checks++;
    if ({cnt_clr_o, cnt_en_o, cmd_ready} !== 3'b011) begin
      n_fail++; $display("FAIL clear_run_return got clr/en/rdy=%b exp=011", {cnt_clr_o, cnt_en_o, cmd_ready});
    end
    cmd(3'd2);
    tick();
    cmd(3'd3);
    tick();
    @(negedge clk);
    n_checks++;
    if ({cnt_clr_o, cnt_en_o, cmd_ready} !== 3'b100) begin
      n_fail++; $display("FAIL clear_stop_pulse got clr/en/rdy=%b exp=100", {cnt_clr_o, cnt_en_o, cmd_ready});
    end
    tick();
    @(negedge clk);
    n_checks++;
    if ({cnt_clr_o, cnt_en_o, cmd_ready} !== 3'b001) begin
      n_fail++; $display("FAIL clear_stop_return got clr/en/rdy=%b exp=001", {cnt_clr_o, cnt_en_o, cmd_ready});
    end
  endtask

  task automatic test_snap_cyc();
    cyc_i = 64'h0000_0005_FFFF_FFF0;
    cmd(3'd4);
    tick();
    cyc_i = 64'h0000_0009_1234_5678;
    rd_c(4'd0, 32'hFFFF_FFF0, 1'b0);
    tick();
    cmd(3'd4);
    tick();
    rd_c(4'd1, 32'h0000_0005, 1'b0);   // hold survives the second snapshot
    tick();
    rd_c(4'd0, 32'h1234_5678, 1'b0);   // back-to-back reads
    tick();
    rd_c(4'd1, 32'h0000_0009, 1'b0);
    tick();
    tick();
    n_checks++;
    if (q_c.size() != 0) begin n_fail++; $display("FAIL snap_cyc_drain got pending=%0d exp=0", q_c.size()); end
  endtask

  task automatic test_snap_cnt();
    for (int k = 0; k < NUM_CNT; k++) cnt_val_i[32*k +: 32] = 32'h100 + k;
    cnt_val_i[32*3 +: 32] = 32'hDEAD_BEEF;
    cmd(3'd4);
    tick();
    rd_d(4'd5, 32'hDEAD_BEEF, 1'b0);
    tick();
    rd_d(4'(NUM_CNT + 2), 32'h0, 1'b1);
    tick();
    rd_d(4'd15, 32'h0, 1'b1);
    tick();
    rd_d(4'd9, 32'h0000_0107, 1'b0);
    tick();
    tick();
    n_checks++;
    if (q_d.size() != 0) begin n_fail++; $display("FAIL snap_cnt_drain got pending=%0d exp=0", q_d.size()); end
  endtask

  task automatic test_arb();
    rd_d(4'd2, 32'h0000_0100, 1'b0);   // lone D grant leaves the pointer on C
    tick();
    for (int i = 0; i < 4; i++) begin
      logic exp_c;
      exp_c = (i % 2 == 0);
      req_c_valid = 1'b1; req_c_addr = 4'd5;
      req_d_valid = 1'b1; req_d_addr = 4'd2;
      @(negedge clk);
      n_checks++;
      if (req_c_ready !== exp_c || req_d_ready !== !exp_c) begin
        n_fail++;
        $display("FAIL arb_grant_%0d got c=%b d=%b exp c=%b d=%b", i, req_c_ready, req_d_ready,
                 exp_c, !exp_c);
      end
      if (exp_c) rd_c(4'd5, 32'hDEAD_BEEF, 1'b0);
      else       rd_d(4'd2, 32'h0000_0100, 1'b0);
      tick();
    end
    tick();
    n_checks++;
    if (q_c.size() + q_d.size() != 0) begin
      n_fail++; $display("FAIL arb_drain got pending=%0d exp=0", q_c.size() + q_d.size());
    end
  endtask

  task automatic test_snap_same_cycle_and_reset();
    cnt_val_i[31:0] = 32'd7;
    cmd(3'd4);
    tick();
    cnt_val_i[31:0] = 32'd9;
    cmd(3'd4);
    rd_c(4'd2, 32'd7, 1'b0);
    tick();
    rd_c(4'd2, 32'd9, 1'b0);
    tick();
    tick();
    n_checks++;
    if (q_c.size() != 0) begin n_fail++; $display("FAIL snap_same_drain got pending=%0d exp=0", q_c.size()); end
    req_c_valid = 1'b1;
    req_c_addr  = 4'd0;
    rst_i = 1'b1;
    tick();
    @(negedge clk);
    n_checks++;
    if (rsp_c_valid !== 1'b0) begin n_fail++; $display("FAIL rst_pending_rsp got=%b exp=0", rsp_c_valid); end
    rst_i = 1'b0;
    rd_c(4'd2, 32'h0, 1'b0);         // shadows cleared by reset
    tick();
    tick();
    n_checks++;
    if (q_c.size() != 0) begin n_fail++; $display("FAIL rst_drain got pending=%0d exp=0", q_c.size()); end
  endtask

  initial begin
    test_reset();
    test_run_stop();
    test_clear();
    test_snap_cyc();
    test_snap_cnt();
    test_arb();
    test_snap_same_cycle_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
